// File: rtl/vector_store_unit.sv
// vector_store_unit
// Drains one captured vector (LANES x LANE_W) into halfword-wide data memory as
// LANES sequential writes. A write is held stable until the memory acknowledges it.
// Every output comes straight from a register.
module vector_store_unit #(
  parameter int LANES  = 16,
  parameter int LANE_W = 16,
  parameter int ADDR_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    st_valid,
  output logic                    st_ready,
  input  logic [LANES*LANE_W-1:0] st_data,
  input  logic [ADDR_W-1:0]       st_addr,
  output logic                    mem_wr_en,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [LANE_W-1:0]       mem_wdata,
  input  logic                    mem_ack,
  output logic                    busy,
  output logic                    done
);

  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

  typedef enum logic {IDLE, WRITE} state_t;

  state_t                  state, state_nxt;
  logic [IDX_W-1:0]        idx, idx_nxt, idx_inc;
  logic [LANES*LANE_W-1:0] vec, vec_nxt;
  logic [ADDR_W-1:0]       base, base_nxt;
  logic                    st_ready_nxt, mem_wr_en_nxt, busy_nxt, done_nxt;
  logic [ADDR_W-1:0]       mem_addr_nxt;
  logic [LANE_W-1:0]       mem_wdata_nxt;

  assign idx_inc = idx + 1'b1;

  // Next-state and next-output logic; outputs are precomputed so they can be registered
  always_comb begin
    state_nxt     = state;
    idx_nxt       = idx;
    vec_nxt       = vec;
    base_nxt      = base;
    st_ready_nxt  = st_ready;
    mem_wr_en_nxt = mem_wr_en;
    busy_nxt      = busy;
    done_nxt      = 1'b0;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    case (state)
      IDLE: begin
        if (st_valid && st_ready) begin
          state_nxt     = WRITE;
          vec_nxt       = st_data;
          base_nxt      = st_addr;
          idx_nxt       = '0;
          st_ready_nxt  = 1'b0;
          busy_nxt      = 1'b1;
          mem_wr_en_nxt = 1'b1;
          mem_addr_nxt  = st_addr;
          mem_wdata_nxt = st_data[LANE_W-1:0];
        end
      end
      WRITE: begin
        // An ack only counts against a live request
        if (mem_ack && mem_wr_en) begin
          if (idx == LAST_IDX) begin
            state_nxt     = IDLE;
            mem_wr_en_nxt = 1'b0;
            busy_nxt      = 1'b0;
            st_ready_nxt  = 1'b1;
            done_nxt      = 1'b1;
          end else begin
            idx_nxt       = idx_inc;
            // Address arithmetic wraps modulo 2^ADDR_W by construction
            mem_addr_nxt  = base + ADDR_W'(idx_inc);
            mem_wdata_nxt = vec[idx_inc*LANE_W +: LANE_W];
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and output registers; reset aborts any in-flight store immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      vec       <= '0;
      base      <= '0;
      st_ready  <= 1'b1;
      mem_wr_en <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      vec       <= vec_nxt;
      base      <= base_nxt;
      st_ready  <= st_ready_nxt;
      mem_wr_en <= mem_wr_en_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_wdata <= mem_wdata_nxt;
    end
  end

endmodule

// File: tb/tb_vector_store_unit.sv
// Directed bench for vector_store_unit: reset with stopped clock, full drain,
// ack stall, address wrap, back-to-back with ignored mid-store request, reset abort.
module tb_vector_store_unit;

  logic         clk = 1'b0;
  logic         clk_en = 1'b0;
  logic         rst = 1'b0;
  logic         st_valid = 1'b0;
  logic         st_ready;
  logic [255:0] st_data = '0;
  logic [15:0]  st_addr = '0;
  logic         mem_wr_en;
  logic [15:0]  mem_addr;
  logic [15:0]  mem_wdata;
  logic         mem_ack = 1'b0;
  logic         busy;
  logic         done;

  int vecs = 0;
  int errs = 0;

  vector_store_unit dut (
    .clk(clk), .rst(rst), .st_valid(st_valid), .st_ready(st_ready),
    .st_data(st_data), .st_addr(st_addr), .mem_wr_en(mem_wr_en),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .busy(busy), .done(done)
  );

  always #5 if (clk_en) clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // lane i = d0 + i
  task automatic set_vec(input logic [15:0] d0);
    for (int i = 0; i < 16; i++) st_data[16*i +: 16] = 16'(d0 + i);
  endtask

  task automatic chk_wr(input logic [15:0] a, input logic [15:0] d);
    chk("wr_en", 32'(mem_wr_en), 32'd1);
    chk("addr", 32'(mem_addr), 32'(a));
    chk("wdata", 32'(mem_wdata), 32'(d));
    chk("busy_wr", 32'(busy), 32'd1);
    chk("ready_wr", 32'(st_ready), 32'd0);
    chk("done_wr", 32'(done), 32'd0);
  endtask

  task automatic chk_done;
    chk("done_pulse", 32'(done), 32'd1);
    chk("wr_en_done", 32'(mem_wr_en), 32'd0);
    chk("busy_done", 32'(busy), 32'd0);
    chk("ready_done", 32'(st_ready), 32'd1);
  endtask

  // Full store with mem_ack held high: writes in cycles 1..16, done in cycle 17
  task automatic run_store(input logic [15:0] base, input logic [15:0] d0);
    set_vec(d0);
    st_addr  = base;
    mem_ack  = 1'b1;
    st_valid = 1'b1;
    tick;
    st_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk_wr(16'(base + i), 16'(d0 + i));
      tick;
    end
    chk_done;
    tick;
    chk("done_clear", 32'(done), 32'd0);
  endtask

  initial begin
    // 1: reset with clock stopped
    #3 rst = 1'b1;
    #2;
    chk("rst_ready", 32'(st_ready), 32'd1);
    chk("rst_wr_en", 32'(mem_wr_en), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    clk_en = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    // ack while idle must not start anything
    mem_ack = 1'b1;
    tick;
    chk("idle_ack_wr_en", 32'(mem_wr_en), 32'd0);
    chk("idle_ack_done", 32'(done), 32'd0);

    // 2: basic drain
    run_store(16'h0100, 16'h3C00);

    // 3: ack stall of 3 cycles at lane 5; done lands at cycle 20
    set_vec(16'h3C00);
    st_addr  = 16'h0100;
    mem_ack  = 1'b1;
    st_valid = 1'b1;
    tick;
    st_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i == 5) begin
        mem_ack = 1'b0;
        for (int k = 0; k < 3; k++) begin
          chk_wr(16'h0105, 16'h3C05);
          tick;
        end
        mem_ack = 1'b1;
      end
      chk_wr(16'(16'h0100 + i), 16'(16'h3C00 + i));
      tick;
    end
    chk_done;
    tick;
    chk("stall_done_clear", 32'(done), 32'd0);

    // 4: address wrap past 0xFFFF
    run_store(16'hFFF8, 16'hA000);

    // 5: mid-store request ignored; held request accepted in the done cycle
    set_vec(16'h3C00);
    st_addr  = 16'h0100;
    st_valid = 1'b1;
    tick;
    st_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk_wr(16'(16'h0100 + i), 16'(16'h3C00 + i));
      if (i == 7) begin
        st_valid = 1'b1;
        set_vec(16'hB000);
        st_addr = 16'h2000;
      end else if (i == 8) begin
        st_valid = 1'b0;
      end else if (i == 15) begin
        st_valid = 1'b1;
      end
      tick;
    end
    chk_done;
    tick;
    st_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk_wr(16'(16'h2000 + i), 16'(16'hB000 + i));
      tick;
    end
    chk_done;
    tick;

    // 6: reset during lane 7 write aborts immediately
    set_vec(16'h3C00);
    st_addr  = 16'h0100;
    st_valid = 1'b1;
    tick;
    st_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      chk_wr(16'(16'h0100 + i), 16'(16'h3C00 + i));
      tick;
    end
    chk_wr(16'h0107, 16'h3C07);
    #2 rst = 1'b1;
    #1;
    chk("abort_wr_en", 32'(mem_wr_en), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_ready", 32'(st_ready), 32'd1);
    chk("abort_done", 32'(done), 32'd0);
    tick;
    tick;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("post_abort_wr_en", 32'(mem_wr_en), 32'd0);
      chk("post_abort_done", 32'(done), 32'd0);
      chk("post_abort_ready", 32'(st_ready), 32'd1);
      tick;
    end
    run_store(16'h0300, 16'h5500);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
